bcd_to_bin_seq: RTL and testbench

- Sequential packed-BCD to unsigned binary converter. It is the inverse of the team's binary-to-BCD double-dabble path.
- Uses reverse double-dabble: shift right one bit per cycle, then subtract 3 from each BCD digit that is >= 8.
- Sits between the BCD digit-entry logic (switch/keypad digits) and the arithmetic datapath that needs a binary operand.
- Uses a start/busy/done handshake, so one instance serves any number of requesters serially.

---
 rtl/bcd_pkg.sv | 29 ++
 rtl/sub3_ge8.sv | 12 +
 rtl/bcd_to_bin_seq.sv | 116 +++++++++++
 tb/tb_bcd_to_bin_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and width helpers for the packed-BCD to binary converter.
package bcd_pkg;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] SUB3_THRESH   = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest w with 2^w >= 10^digits, i.e. enough bits for the all-nines operand.
  function automatic int min_bin_w(input int digits);
    longint unsigned lim;
    int              w;
    lim = 64'd1;
    w   = 0;
    for (int i = 0; i < digits; i++) lim = lim * 64'd10;
    while (w < 63 && (64'd1 << w) < lim) w++;
    return w;
  endfunction

  function automatic logic digit_valid(input logic [BCD_DIGIT_W-1:0] d);
    return d <= BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/sub3_ge8.sv
// Reverse double-dabble digit correction: subtract 3 from a shifted BCD digit that reached 8 or more.
// Purely combinational, no handshake.
module sub3_ge8
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] fixed
);

  assign fixed = (digit >= SUB3_THRESH) ? digit - 4'd3 : digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Packed-BCD to binary via reverse double-dabble; result BIN_W+1 edges after the accepting edge.
// start is taken only in IDLE and never queued; BCD_TO_BIN_DIGIT_CHECK_EN adds invalid-digit rejection (err).
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] in_BCD,
  output logic [BIN_W-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_width
    $error("bcd_to_bin_seq: BIN_W cannot hold 10^DIGITS-1");
  end

  state_t             state, state_nxt;
  logic [BCD_W-1:0]   bcd_r, bcd_shift, bcd_fix;
  logic [BIN_W-1:0]   bin_r;
  logic [CNT_W-1:0]   cnt;
  logic               bad_digit;
  logic               inv_r;

  // Right shift of the BCD half; its LSB moves into the binary half below.
  assign bcd_shift = bcd_r >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_fix
    sub3_ge8 u_fix (
      .digit (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .fixed (bcd_fix[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = bad_digit ? DONE : SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bcd_r <= '0;
      bin_r <= '0;
      cnt   <= '0;
      bin   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          bcd_r <= in_BCD;
          bin_r <= '0;
          cnt   <= '0;
        end
        SHIFT: begin
          bcd_r <= bcd_fix;
          bin_r <= {bcd_r[0], bin_r[BIN_W-1:1]};
          cnt   <= cnt + 1'b1;
        end
        DONE: begin
          done <= 1'b1;
          bin  <= inv_r ? '0 : bin_r;
          // Every BCD bit has migrated into bin_r once a valid operand is fully converted.
          assert (inv_r || bcd_r == '0);
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_valid(in_BCD[i*BCD_DIGIT_W +: BCD_DIGIT_W])) bad_digit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inv_r <= 1'b0;
      err   <= 1'b0;
    end else if (state == IDLE && start) begin
      inv_r <= bad_digit;
      err   <= 1'b0;
    end else if (state == DONE) begin
      err <= inv_r;
    end
  end
`else
  assign bad_digit = 1'b0;
  assign inv_r     = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized self-checking bench for bcd_to_bin_seq against an arithmetic decimal-value model.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [4*DIGITS-1:0] in_BCD;
  logic [BIN_W-1:0]  bin;
  logic              busy;
  logic              done;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .in_BCD (in_BCD),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Decimal value of a packed BCD word: sum of digit * 10^position.
  function automatic int ref_bin(input logic [4*DIGITS-1:0] b);
    int v = 0;
    int p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v += int'(b[i*4 +: 4]) * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic bit has_bad_digit(input logic [4*DIGITS-1:0] b);
    bit r = 1'b0;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    for (int i = 0; i < DIGITS; i++) if (b[i*4 +: 4] > 4'd9) r = 1'b1;
`endif
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] rand_bcd();
    logic [4*DIGITS-1:0] b;
    for (int i = 0; i < DIGITS; i++) b[i*4 +: 4] = 4'($urandom_range(0, 9));
    return b;
  endfunction

  // One conversion: launch, scramble inputs while busy, optionally poke start mid-run.
  task automatic run_conv(input logic [4*DIGITS-1:0] b, input bit poke);
    int edges;
    int bc;
    bit bad;
    logic [BIN_W-1:0] held;
    bad = has_bad_digit(b);
    @(negedge clk);
    in_BCD = b;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    bc    = 0;
    while (!done && edges < 60) begin
      if (busy) bc++;
      if (poke && edges == 3) start = 1'b1;
      if (edges == 4) start = 1'b0;
      in_BCD = 12'($urandom);
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    check("latency", edges - 1, bad ? 1 : BIN_W + 1);
    check("busy_cycles", bc, bad ? 0 : BIN_W);
    check("bin", bin, bad ? 0 : ref_bin(b));
    check("err", err, bad);
    held = bin;
    @(negedge clk);
    check("done_width", done, 1'b0);
    check("bin_hold", bin, held);
  endtask

  initial begin
    int cyc, first, second, unstable, cnt_done;
    logic [BIN_W-1:0] b1, b2;

    rst_n  = 1'b0;
    start  = 1'b0;
    in_BCD = '0;
    repeat (3) @(negedge clk);
    check("rst_bin", bin, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    run_conv(12'h999, 1'b0);
    run_conv(12'h000, 1'b0);
    run_conv(12'h001, 1'b0);
    run_conv(12'h100, 1'b0);
    run_conv(12'h509, 1'b0);
    run_conv(12'h358, 1'b1);

    // Reset during SHIFT aborts without a done pulse.
    @(negedge clk);
    in_BCD = 12'h742;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bin", bin, 0);
    check("abort_err", err, 0);
    rst_n    = 1'b1;
    cnt_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    check("abort_no_done", cnt_done, 0);
    run_conv(12'h742, 1'b0);

    // start held high: back-to-back conversions.
    @(negedge clk);
    in_BCD   = 12'h123;
    start    = 1'b1;
    cyc      = 0;
    first    = -1;
    second   = -1;
    unstable = 0;
    b1       = '0;
    b2       = '0;
    while (second < 0 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (first < 0) begin
          first  = cyc;
          b1     = bin;
          in_BCD = 12'h456;
        end else begin
          second = cyc;
          b2     = bin;
          start  = 1'b0;
        end
      end else if (first >= 0 && bin !== b1) begin
        unstable++;
      end
    end
    start = 1'b0;
    check("b2b_gap", second - first, BIN_W + 2);
    check("b2b_first", b1, 123);
    check("b2b_second", b2, 456);
    check("b2b_stable", unstable, 0);
    repeat (3) @(negedge clk);

    repeat (25) run_conv(rand_bcd(), 1'($urandom_range(0, 1)));

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    run_conv(12'h1A3, 1'b0);
    run_conv(12'h123, 1'b0);
    run_conv(12'hF09, 1'b0);
    run_conv(12'h990, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
